// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard for issue stalling.
// Two combinational read ports with writeback bypass, one synchronous write port, x0 hardwired to 0.
module regfile_scoreboard #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic [WORD_SIZE-1:0] rs1_data,
  output logic [WORD_SIZE-1:0] rs2_data,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 issue_uses_rs1,
  input  logic                 issue_uses_rs2,
  output logic                 hazard,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  logic wr_live;
  logic clr1, clr2, clr_rd;
  logic haz_rs1, haz_rs2, haz_rd;
  logic accept;

  assign wr_live = wr_en && (wr_addr != '0);

  // Register storage; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Reads bypass the in-flight writeback; held at zero during reset so the bypass cannot leak.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (!rst) begin
      if (rs1_addr != '0) begin
        rs1_data = (wr_en && (wr_addr == rs1_addr)) ? wr_data : regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
        rs2_data = (wr_en && (wr_addr == rs2_addr)) ? wr_data : regs_q[rs2_addr];
      end
    end
  end

  // A writeback landing this cycle resolves the dependency it would otherwise stall on.
  always_comb begin
    clr1    = wr_en && (wr_addr == rs1_addr);
    clr2    = wr_en && (wr_addr == rs2_addr);
    clr_rd  = wr_en && (wr_addr == issue_rd);
    haz_rs1 = issue_uses_rs1 && busy_q[rs1_addr] && !clr1;
    haz_rs2 = issue_uses_rs2 && busy_q[rs2_addr] && !clr2;
    haz_rd  = (issue_rd != '0) && busy_q[issue_rd] && !clr_rd;
    hazard  = issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
    accept  = issue_valid && !hazard && !flush;
  end

  // Clear first, then set, so an accepted issue wins over a same-cycle writeback of the same reg.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_live) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (accept && (issue_rd != '0)) begin
        busy_d[issue_rd] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic,
// compared against an array/bitmask model of the register file and scoreboard.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        wr_en, issue_valid, issue_uses_rs1, issue_uses_rs2, hazard, flush;
  logic [31:0] busy_vec;

  int nerr;
  int nchk;

  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  regfile_scoreboard #(
    .WORD_SIZE(32),
    .NUM_REGS (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_uses_rs1(issue_uses_rs1),
    .issue_uses_rs2(issue_uses_rs2),
    .hazard        (hazard),
    .flush         (flush),
    .busy_vec      (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_addr = 0; rs2_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_valid = 0; issue_rd = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; flush = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 0;
    mbusy = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_hazard();
    logic h;
    h = 0;
    if (issue_uses_rs1 && mbusy[rs1_addr] && !(wr_en && wr_addr == rs1_addr)) h = 1;
    if (issue_uses_rs2 && mbusy[rs2_addr] && !(wr_en && wr_addr == rs2_addr)) h = 1;
    if (issue_rd != 0 && mbusy[issue_rd] && !(wr_en && wr_addr == issue_rd)) h = 1;
    return issue_valid && h;
  endfunction

  // Called at a negedge with inputs already driven: checks combinational outputs,
  // clocks once, then checks the registered busy vector against the model.
  task automatic step(input string tag);
    logic [31:0] nbusy;
    logic        acc;
    #1;
    chk({tag, ".rs1"}, rs1_data, exp_read(rs1_addr));
    chk({tag, ".rs2"}, rs2_data, exp_read(rs2_addr));
    chk({tag, ".haz"}, {31'b0, hazard}, {31'b0, exp_hazard()});
    acc   = issue_valid && !exp_hazard() && !flush;
    nbusy = mbusy;
    if (flush) nbusy = 0;
    else begin
      if (wr_en && wr_addr != 0) nbusy[wr_addr] = 0;
      if (acc && issue_rd != 0) nbusy[issue_rd] = 1;
    end
    @(posedge clk);
    if (wr_en && wr_addr != 0) mreg[wr_addr] = wr_data;
    mbusy = nbusy;
    #1;
    chk({tag, ".busy"}, busy_vec, mbusy);
    @(negedge clk);
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    idle();
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.busy", busy_vec, 0);
    rst = 0;
    @(negedge clk);

    // Reset mid-run: data and busy cleared immediately, no clock needed
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; step("rst_wr");
    idle(); issue_valid = 1; issue_rd = 6; step("rst_iss");
    idle(); rs1_addr = 5; step("rst_rd");
    chk("rst.pre_busy6", {31'b0, busy_vec[6]}, 1);
    #2 rst = 1;
    #1;
    chk("rst.async_rs1", rs1_data, 0);
    chk("rst.async_busy", busy_vec, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle();

    // x0 is hardwired zero and never becomes busy
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; step("x0_wr");
    idle(); rs1_addr = 0; issue_valid = 1; issue_rd = 0; issue_uses_rs1 = 1; step("x0_iss");
    chk("x0.busy", busy_vec, 0);

    // Same-cycle bypass, then the stored value
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rs2_addr = 7; #1;
    chk("byp.rs2", rs2_data, 32'hA5A5A5A5);
    step("byp");
    idle(); rs2_addr = 7; #1;
    chk("byp.stored", rs2_data, 32'hA5A5A5A5);
    step("byp_after");

    // RAW hazard and its resolution by writeback
    idle(); issue_valid = 1; issue_rd = 3; step("raw_iss");
    idle(); issue_valid = 1; issue_uses_rs1 = 1; rs1_addr = 3; #1;
    chk("raw.haz", {31'b0, hazard}, 1);
    step("raw_stall");
    wr_en = 1; wr_addr = 3; wr_data = 32'h10; #1;
    chk("raw.clr_haz", {31'b0, hazard}, 0);
    chk("raw.clr_rs1", rs1_data, 32'h10);
    step("raw_clr");
    chk("raw.busy3", {31'b0, busy_vec[3]}, 0);

    // Set wins over clear of the same register
    idle(); issue_valid = 1; issue_rd = 4; step("sc_iss");
    idle(); wr_en = 1; wr_addr = 4; wr_data = 32'hCAFE0004; issue_valid = 1; issue_rd = 4;
    step("sc_both");
    chk("sc.busy4", {31'b0, busy_vec[4]}, 1);
    idle(); rs1_addr = 4; step("sc_rd");

    // Flush with concurrent writeback
    idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h44; step("fl_drain");
    idle(); issue_valid = 1; issue_rd = 2; step("fl_s2");
    issue_rd = 3; step("fl_s3");
    issue_rd = 9; step("fl_s9");
    chk("fl.pre", busy_vec, 32'h0000_020C);
    idle(); flush = 1; wr_en = 1; wr_addr = 9; wr_data = 32'h55; issue_valid = 1; issue_rd = 5;
    step("fl_do");
    chk("fl.busy", busy_vec, 0);
    idle(); rs1_addr = 9; step("fl_rd");
    chk("fl.x9", rs1_data, 32'h55);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rs1_addr       = 5'($urandom_range(0, 7));
      rs2_addr       = 5'($urandom_range(0, 7));
      wr_en          = 1'($urandom_range(0, 1));
      wr_addr        = 5'($urandom_range(0, 7));
      wr_data        = $urandom;
      issue_valid    = 1'($urandom_range(0, 1));
      issue_rd       = 5'($urandom_range(0, 7));
      issue_uses_rs1 = 1'($urandom_range(0, 1));
      issue_uses_rs2 = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 19) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
